// File: rtl/decoder_4to16.sv
// Registered 4-to-16 one-hot decoder with valid, latched select and event counter.
// Optional active-low strobe bus dec_n when DECODER_ACTLOW_OUT_EN is defined.
module decoder_4to16 #(
  parameter int REG_OUT = 1,
  parameter int CNT_W   = 8,
  parameter int CNT_SAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [15:0]      dec,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             en_n,
  output logic             dec_vld,
  output logic [3:0]       sel_q,
  output logic [CNT_W-1:0] dec_cnt
`ifdef DECODER_ACTLOW_OUT_EN
  ,
  output logic [15:0]      dec_n
`endif
);

  logic [3:0]       sel;
  logic [15:0]      hot;
  logic [CNT_W-1:0] cnt_nxt;

  assign sel = {a, b, c, d};

  always_comb begin
    hot = '0;
    if (!en_n) hot[sel] = 1'b1;
  end

  always_comb begin
    cnt_nxt = dec_cnt + CNT_W'(1);
    if (CNT_SAT != 0 && dec_cnt == '1)
      cnt_nxt = dec_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      dec_cnt <= '0;
    end else if (!en_n) begin
      sel_q   <= sel;
      dec_cnt <= cnt_nxt;
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic [15:0] dec_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dec_q <= '0;
      else        dec_q <= hot;
    end

    assign dec = dec_q;
  end else begin : g_comb
    // Forced low during reset so both modes share the same reset view.
    assign dec = rst_n ? hot : '0;
  end

  assign dec_vld = |dec;

`ifdef DECODER_ACTLOW_OUT_EN
  assign dec_n = ~dec;
`endif

endmodule

// File: tb/tb_decoder_4to16.sv
// Directed bench for decoder_4to16: registered, combinational and
// narrow-counter (wrap/saturate) instances driven from shared inputs.
module tb_decoder_4to16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic en_n = 1'b1;

  logic [15:0] dec0, dec1, dec2, dec3;
  logic        vld0, vld1, vld2, vld3;
  logic [3:0]  sel0, sel1, sel2, sel3;
  logic [7:0]  cnt0, cnt3;
  logic [1:0]  cnt1, cnt2;
`ifdef DECODER_ACTLOW_OUT_EN
  logic [15:0] decn0, decn1, decn2, decn3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_4to16 #(.REG_OUT(1), .CNT_W(8), .CNT_SAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .dec(dec0),
    .a(a), .b(b), .c(c), .d(d), .en_n(en_n),
    .dec_vld(vld0), .sel_q(sel0), .dec_cnt(cnt0)
`ifdef DECODER_ACTLOW_OUT_EN
    , .dec_n(decn0)
`endif
  );

  decoder_4to16 #(.REG_OUT(1), .CNT_W(2), .CNT_SAT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .dec(dec1),
    .a(a), .b(b), .c(c), .d(d), .en_n(en_n),
    .dec_vld(vld1), .sel_q(sel1), .dec_cnt(cnt1)
`ifdef DECODER_ACTLOW_OUT_EN
    , .dec_n(decn1)
`endif
  );

  decoder_4to16 #(.REG_OUT(1), .CNT_W(2), .CNT_SAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .dec(dec2),
    .a(a), .b(b), .c(c), .d(d), .en_n(en_n),
    .dec_vld(vld2), .sel_q(sel2), .dec_cnt(cnt2)
`ifdef DECODER_ACTLOW_OUT_EN
    , .dec_n(decn2)
`endif
  );

  decoder_4to16 #(.REG_OUT(0), .CNT_W(8), .CNT_SAT(0)) u3 (
    .clk(clk), .rst_n(rst_n), .dec(dec3),
    .a(a), .b(b), .c(c), .d(d), .en_n(en_n),
    .dec_vld(vld3), .sel_q(sel3), .dec_cnt(cnt3)
`ifdef DECODER_ACTLOW_OUT_EN
    , .dec_n(decn3)
`endif
  );

  typedef struct {
    logic [3:0]  code;
    logic [15:0] dec;
  } vec_t;

  vec_t       sweep[16];
  logic [1:0] wrap_exp[5];
  logic [1:0] sat_exp[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_code(input logic [3:0] k);
    {a, b, c, d} = k;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse spanning one rising edge; returns on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    sweep[0]  = '{4'h0, 16'h0001}; sweep[1]  = '{4'h1, 16'h0002};
    sweep[2]  = '{4'h2, 16'h0004}; sweep[3]  = '{4'h3, 16'h0008};
    sweep[4]  = '{4'h4, 16'h0010}; sweep[5]  = '{4'h5, 16'h0020};
    sweep[6]  = '{4'h6, 16'h0040}; sweep[7]  = '{4'h7, 16'h0080};
    sweep[8]  = '{4'h8, 16'h0100}; sweep[9]  = '{4'h9, 16'h0200};
    sweep[10] = '{4'ha, 16'h0400}; sweep[11] = '{4'hb, 16'h0800};
    sweep[12] = '{4'hc, 16'h1000}; sweep[13] = '{4'hd, 16'h2000};
    sweep[14] = '{4'he, 16'h4000}; sweep[15] = '{4'hf, 16'h8000};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset with a decode pending, before any clock edge
    en_n = 1'b0;
    set_code(4'b0101);
    #2;
    chk("rst_dec", 32'(dec0), 32'h0);
    chk("rst_vld", 32'(vld0), 32'h0);
    chk("rst_sel", 32'(sel0), 32'h0);
    chk("rst_cnt", 32'(cnt0), 32'h0);
    chk("rst_comb_dec", 32'(dec3), 32'h0);
    chk("rst_comb_vld", 32'(vld3), 32'h0);
`ifdef DECODER_ACTLOW_OUT_EN
    chk("rst_decn_reg", 32'(decn0), 32'hffff);
    chk("rst_decn_comb", 32'(decn3), 32'hffff);
`endif
    step();
    step();
    chk("rst_hold_dec", 32'(dec0), 32'h0);
    chk("rst_hold_cnt", 32'(cnt0), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_comb_dec", 32'(dec3), 32'h0020);
    chk("rel_reg_pre", 32'(dec0), 32'h0);
    step();
    chk("rel_dec", 32'(dec0), 32'h0020);
    chk("rel_vld", 32'(vld0), 32'h1);
    chk("rel_sel", 32'(sel0), 32'h5);
    chk("rel_cnt", 32'(cnt0), 32'h1);

    // Full sweep, one code per cycle, no bubbles
    en_n = 1'b1;
    do_reset();
    en_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_code(sweep[i].code);
      #1;
      chk("sweep_comb", 32'(dec3), 32'(sweep[i].dec));
      step();
      chk("sweep_dec", 32'(dec0), 32'(sweep[i].dec));
      chk("sweep_vld", 32'(vld0), 32'h1);
      chk("sweep_sel", 32'(sel0), 32'(sweep[i].code));
      chk("sweep_cnt", 32'(cnt0), 32'(i + 1));
`ifdef DECODER_ACTLOW_OUT_EN
      chk("sweep_decn", 32'(decn0), 32'(~sweep[i].dec));
`endif
    end
    chk("sweep_cnt_end", 32'(cnt0), 32'd16);
    chk("sweep_comb_sel", 32'(sel3), 32'hf);
    chk("sweep_comb_cnt", 32'(cnt3), 32'd16);

    // Disable holds sel_q and dec_cnt
    en_n = 1'b1;
    set_code(4'b1010);
    #1;
    chk("dis_comb_dec", 32'(dec3), 32'h0);
    chk("dis_comb_vld", 32'(vld3), 32'h0);
    step();
    chk("dis_dec", 32'(dec0), 32'h0);
    chk("dis_vld", 32'(vld0), 32'h0);
    chk("dis_sel", 32'(sel0), 32'hf);
    chk("dis_cnt", 32'(cnt0), 32'd16);
    step();
    chk("dis_cnt2", 32'(cnt0), 32'd16);

    // Asynchronous reset between edges mid-sweep
    do_reset();
    en_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_code(4'(i));
      step();
    end
    chk("mid_pre_dec", 32'(dec0), 32'h0080);
    chk("mid_pre_cnt", 32'(cnt0), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dec", 32'(dec0), 32'h0);
    chk("mid_rst_vld", 32'(vld0), 32'h0);
    chk("mid_rst_sel", 32'(sel0), 32'h0);
    chk("mid_rst_cnt", 32'(cnt0), 32'h0);
    chk("mid_rst_comb", 32'(dec3), 32'h0);
    @(negedge clk);
    set_code(4'h8);
    rst_n = 1'b1;
    step();
    chk("mid_rel_dec", 32'(dec0), 32'h0100);
    chk("mid_rel_cnt", 32'(cnt0), 32'd1);
    chk("mid_rel_sel", 32'(sel0), 32'h8);

    // Narrow counter: wrap vs saturate
    en_n = 1'b1;
    do_reset();
    en_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_code(4'(i + 9));
      step();
      chk("cnt_wrap", 32'(cnt1), 32'(wrap_exp[i]));
      chk("cnt_sat", 32'(cnt2), 32'(sat_exp[i]));
    end
    chk("cnt_wrap_dec", 32'(dec1), 32'h2000);
    chk("cnt_sat_dec", 32'(dec2), 32'h2000);

    // Combinational path with code 0011
    set_code(4'b0011);
    #1;
    chk("comb_0011_dec", 32'(dec3), 32'h0008);
    chk("comb_0011_vld", 32'(vld3), 32'h1);
`ifdef DECODER_ACTLOW_OUT_EN
    chk("comb_0011_decn", 32'(decn3), 32'hfff7);
`endif
    step();
    chk("comb_0011_sel", 32'(sel3), 32'h3);
    chk("reg_0011_dec", 32'(dec0), 32'h0008);

    en_n = 1'b1;
    #1;
    chk("comb_off_dec", 32'(dec3), 32'h0);
`ifdef DECODER_ACTLOW_OUT_EN
    chk("comb_off_decn", 32'(decn3), 32'hffff);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_4to16.md
Name: decoder_4to16

Overview:
- Registered 4-to-16 one-hot address decoder with active-low enable.
- Converts a 4-bit select, driven as four scalar bits a (MSB), b, c, d (LSB), into a one-hot 16-bit strobe bus.
- Used for chip-select and register-select generation in the datapath.
- Also provides a valid flag, the latched select code and a saturating/wrapping decode counter for debug.

Parameters:
- REG_OUT, 1: 1 = outputs registered (1-cycle latency); 0 = dec/dec_vld combinational from inputs, held at 0 while rst_n is low.
- CNT_W, 8: width of decode event counter dec_cnt.
- CNT_SAT, 0: 0 = counter wraps at 2^CNT_W-1 -> 0; 1 = counter saturates at all-ones.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- dec, output, 16: one-hot decode. Bit index k equals {a,b,c,d} interpreted as unsigned 0..15. Bit 0 asserts for code 0000, bit 15 for code 1111.
- a, input, 1: select bit 3 (MSB).
- b, input, 1: select bit 2.
- c, input, 1: select bit 1.
- d, input, 1: select bit 0 (LSB).
- en_n, input, 1: active-low enable. 0 = decode; 1 = all outputs deasserted.
- dec_vld, output, 1: high when dec carries a decode (exactly one bit set).
- sel_q, output, 4: select code of the most recent enabled decode. Holds its value while disabled.
- dec_cnt, output, CNT_W: number of enabled decode cycles since reset.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately irrespective of clk):
  - dec = 16'h0000, dec_vld = 0, sel_q = 4'h0, dec_cnt = 0.
  - The reset value of dec applies in both REG_OUT modes.
- Release of rst_n is sampled synchronously; the first update occurs on the first rising clk edge with rst_n high.
- REG_OUT=1, on each rising clk edge:
  - en_n=0: dec <= 16'b1 << {a,b,c,d}; dec_vld <= 1; sel_q <= {a,b,c,d}; dec_cnt increments.
  - en_n=1: dec <= 0; dec_vld <= 0; sel_q holds; dec_cnt holds.
- REG_OUT=0:
  - dec and dec_vld follow the same function combinationally, with zero latency.
  - sel_q and dec_cnt remain registered exactly as in REG_OUT=1.
- Invariants:
  - dec is always either all-zero or exactly one-hot; it is never multi-hot.
  - dec_vld equals the OR-reduction of dec.
- X/Z on a/b/c/d with en_n=0: no requirement on dec; this is a bench error.
- Counter boundary at 2^CNT_W-1 with an enabled decode:
  - CNT_SAT=0: wraps to 0.
  - CNT_SAT=1: stays at all-ones.
- Reset asserted mid-stream: all outputs clear within the same delta, with no clock required. A pending decode is discarded.
- Back-to-back enabled cycles with changing codes: each cycle's code appears on dec the following cycle, with no bubbles.

Optional Feature:
- Macro: DECODER_ACTLOW_OUT_EN.
- Defined:
  - Adds output port dec_n (16 bits) = bitwise inverse of dec, i.e. an active-low strobe bus.
  - Reset value of dec_n is 16'hFFFF.
  - Timing and latency are identical to dec.
- Undefined: dec_n does not exist; the rest of the behaviour is unchanged.

Test Plan:
- Reset: rst_n=0 with en_n=0, abcd=0101 -> dec=0000, dec_vld=0, dec_cnt=0 with no clock edge. Release reset -> next edge gives dec=16'h0020.
- Full sweep: en_n=0, abcd stepped 0000..1111 one per cycle (REG_OUT=1).
  - Each code k shows dec = 1<<k one cycle later (0000->0001, 0001->0002, ..., 1111->8000).
  - dec_vld=1 throughout; sel_q=k.
  - dec_cnt=16 after the sweep.
- Disable: en_n=1 with abcd=1010 -> dec=0000, dec_vld=0 next cycle. sel_q and dec_cnt unchanged from their prior values.
- Reset mid-operation: assert rst_n low between clk edges during the sweep at code 0111 -> dec drops from 0080 to 0000 immediately. Count restarts from 0 after release.
- Counter boundary (CNT_W=2): 5 enabled cycles.
  - CNT_SAT=0: dec_cnt sequence 1,2,3,0,1.
  - CNT_SAT=1: dec_cnt sequence 1,2,3,3,3.
- With DECODER_ACTLOW_OUT_EN defined and REG_OUT=0:
  - abcd=0011, en_n=0 -> dec=0008, dec_n=FFF7 combinationally.
  - During reset, dec_n=FFFF.
